// File: rtl/inst_mem_loader.sv
// -----------------------------------------------------------------------------
// inst_mem_loader
//
// Write-side loader for the instruction memory. A program image arrives as a
// little-endian byte stream. The loader packs each group of four bytes into a
// 32-bit instruction word and writes it to the memory, one word per write
// strobe. Words are written at consecutive byte addresses starting at 0, using
// the same byte-address convention as the PC (the memory indexes by addr >> 2).
//
// Ports
//   i_clk         rising-edge clock
//   i_rst_n       asynchronous active-low reset
//   i_start       one-cycle pulse; begins a load from IDLE, DONE or ERR
//   i_byte_valid  i_byte_data holds a byte
//   i_byte_data   program byte
//   i_byte_last   marks the final byte of the image (only with i_byte_valid)
//   o_byte_ready  loader accepts a byte this cycle
//   o_wr_en       one-cycle write strobe to instruction memory
//   o_wr_addr     byte address of the word being written (bits [1:0] = 0)
//   o_wr_data     assembled instruction word
//   o_busy        load in progress (RECV or WRITE)
//   o_done        image fully written (held until the next start)
//   o_error       image longer than DEPTH words (held until the next start)
// -----------------------------------------------------------------------------
module inst_mem_loader #(
    parameter int DEPTH = 18
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte_data,
    input  logic        i_byte_last,
    output logic        o_byte_ready,
    output logic        o_wr_en,
    output logic [31:0] o_wr_addr,
    output logic [31:0] o_wr_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error
);

    // The word index has to be able to reach DEPTH after the final increment.
    localparam int IDX_W = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [IDX_W-1:0] r_word_idx;
    logic [2:0]       r_byte_cnt;
    logic [31:0]      r_asm;
    logic             r_last;
    logic [31:0]      r_wr_addr;
    logic [31:0]      r_wr_data;

    logic             w_start;
    logic             w_accept;
    logic             w_word_full;
    logic             w_last_slot;
    logic [31:0]      w_asm_new;

    // start is only honoured when no load is running.
    assign w_start     = i_start && ((r_state == S_IDLE) ||
                                     (r_state == S_DONE) ||
                                     (r_state == S_ERR));
    assign w_accept    = (r_state == S_RECV) && i_byte_valid;
    assign w_word_full = w_accept && ((r_byte_cnt == 3'd3) || i_byte_last);
    assign w_last_slot = (r_word_idx == IDX_W'(DEPTH - 1));

    // Drop the incoming byte into its lane. The assembly register is cleared
    // at the start of every word, so lanes above a mid-word last byte stay 0.
    always_comb begin
        w_asm_new = r_asm;
        case (r_byte_cnt[1:0])
            2'd0:    w_asm_new[7:0]   = i_byte_data;
            2'd1:    w_asm_new[15:8]  = i_byte_data;
            2'd2:    w_asm_new[23:16] = i_byte_data;
            default: w_asm_new[31:24] = i_byte_data;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and state-decoded outputs.
    always_comb begin
        w_state_next = r_state;
        o_byte_ready = 1'b0;
        o_wr_en      = 1'b0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        o_error      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_next = S_RECV;
                end
            end
            S_RECV: begin
                o_byte_ready = 1'b1;
                o_busy       = 1'b1;
                if (w_word_full) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                o_wr_en = 1'b1;
                o_busy  = 1'b1;
                // A final byte in the last slot still counts as a clean finish.
                if (r_last) begin
                    w_state_next = S_DONE;
                end else if (w_last_slot) begin
                    w_state_next = S_ERR;
                end else begin
                    w_state_next = S_RECV;
                end
            end
            S_DONE: begin
                o_done = 1'b1;
                if (w_start) begin
                    w_state_next = S_RECV;
                end
            end
            S_ERR: begin
                o_error = 1'b1;
                if (w_start) begin
                    w_state_next = S_RECV;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath. The write address and data are captured on the edge that
    // completes a word, so they are valid throughout WRITE and then simply
    // hold until the next word completes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_word_idx <= '0;
            r_byte_cnt <= '0;
            r_asm      <= '0;
            r_last     <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else if (w_start) begin
            r_word_idx <= '0;
            r_byte_cnt <= '0;
            r_asm      <= '0;
            r_last     <= 1'b0;
        end else if (w_accept) begin
            if (w_word_full) begin
                r_wr_data <= w_asm_new;
                r_wr_addr <= {{(30 - IDX_W){1'b0}}, r_word_idx, 2'b00};
                r_last    <= i_byte_last;
            end else begin
                r_asm      <= w_asm_new;
                r_byte_cnt <= r_byte_cnt + 3'd1;
            end
        end else if (r_state == S_WRITE) begin
            r_word_idx <= r_word_idx + {{(IDX_W - 1){1'b0}}, 1'b1};
            r_byte_cnt <= '0;
            r_asm      <= '0;
        end
    end

    assign o_wr_addr = r_wr_addr;
    assign o_wr_data = r_wr_data;

endmodule

// File: doc/inst_mem_loader.md
# inst_mem_loader

Writer side of the instruction memory: receives a program as a little-endian byte stream, assembles 32-bit instruction words and issues one-cycle word writes with sequential byte addresses, starting at 0. It sits between a host/bench byte source and the instruction memory write port. It lets the program image be loaded at run time instead of from initial contents. The memory keeps indexing by `PC >> 2`, so `wr_addr` uses the same byte-address convention as `PC`.

## Interface
- `DEPTH`, 18, number of 32-bit words in the target instruction memory (word indices 0..DEPTH-1)
- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  asynchronous, active-low reset
- `start`  input  1  one-cycle pulse; begins a load (honoured in IDLE, DONE, ERR)
- `byte_valid`  input  1  `byte_data` holds a byte
- `byte_data`  input  8  program byte
- `byte_last`  input  1  qualifies the final byte of the image (sampled with `byte_valid`)
- `byte_ready`  output  1  loader accepts a byte this cycle
- `wr_en`  output  1  one-cycle write strobe to instruction memory
- `wr_addr`  output  32  byte address of the word being written (word_idx << 2, bits [1:0] always 0)
- `wr_data`  output  32  assembled instruction word
- `busy`  output  1  load in progress (RECV or WRITE)
- `done`  output  1  image fully written
- `error`  output  1  image exceeded DEPTH words

## Operation
- States: IDLE, RECV, WRITE, DONE, ERR.
- IDLE: `byte_ready`=0. On `start`, the loader clears word_idx, byte_cnt and the assembly register, then goes to RECV.
- RECV: `byte_ready`=1. A byte is accepted when `byte_valid && byte_ready`.
  - The byte is placed at lane byte_cnt (byte 0 -> [7:0], byte 3 -> [31:24]) and byte_cnt increments.
  - The loader goes to WRITE when byte_cnt reaches 4 or when the accepted byte has `byte_last`=1.
  - On `byte_last` mid-word, the unfilled upper lanes are zero.
- WRITE: `byte_ready`=0, `wr_en`=1 for exactly this cycle.
  - `wr_addr` = {word_idx, 2'b00}, `wr_data` = assembly register.
  - Then word_idx increments, byte_cnt and the assembly register clear.
  - Next state, in priority order:
    - DONE if this word held the last byte.
    - ERR if word_idx was DEPTH-1.
    - Otherwise RECV.
- DONE: `done`=1 and is held. `start` begins a new load.
- ERR: `error`=1 and is held, `byte_ready`=0, no writes. `start` begins a new load.
  - A final byte landing exactly in word DEPTH-1 ends in DONE, not ERR.
- `start` while busy is ignored.
- `byte_last` without `byte_valid` is ignored.
- A zero-length image cannot occur: DONE requires an accepted `byte_last`.
- `busy` = state is RECV or WRITE.
- word_idx is wide enough to hold DEPTH, i.e. $clog2(DEPTH+1) bits.

## Timing
- Reset (asynchronous, `rst_n`=0) forces IDLE immediately. All outputs are then 0: `byte_ready`, `wr_en`, `wr_addr`, `wr_data`, `busy`, `done`, `error`.
- Reset mid-load aborts with no further `wr_en`. Words already written stay in memory.
- All outputs are registered or decoded from state. There are no combinational paths from `byte_valid`/`byte_data` to outputs.
- Latency: 4th (or last) byte accepted at edge N -> `wr_en` high during cycle N+1 -> `byte_ready` high again in cycle N+2.
  - Sustained throughput is 4 bytes per 5 cycles.
- `start` at edge N puts the loader in RECV, so `byte_ready`=1 in cycle N+1.
- `done`/`error` rise in the cycle after the final WRITE cycle.
- `wr_addr`/`wr_data` hold their last written values outside WRITE. Only `wr_en` qualifies them.

## Test plan
- Reset, then `start`. Bytes 93 02 10 00 33 83 52 00, with `byte_last` on the 8th byte:
  - Writes (addr 0x0, 0x00100293) then (addr 0x4, 0x00528333).
  - `done`=1 one cycle after the second write.
- Bytes 13 04 with `byte_last` on 04 -> a single write (0x0, 0x00000413), then DONE.
- `byte_valid` toggled every other cycle through a 4-byte word -> identical data, written once, with no byte lost or duplicated.
- DEPTH=18, stream 73 bytes:
  - 18 writes at 0x00..0x44.
  - ERR after the 18th write, `error`=1, `byte_ready`=0.
  - The next `start` clears `error` and writes again from 0x0.
- DEPTH=18, exactly 72 bytes with `byte_last` on byte 72 -> last write at 0x44, DONE, `error`=0.
- Drop `rst_n` during cycle 2 of the second word -> all outputs 0 asynchronously and no `wr_en`. `start` after release reloads from 0x0.
